// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Optional macro ALU_ARB_OPCNT_EN builds saturating per-port completed-operation counters.
`timescale 1ns/1ps
module alu_share_arbiter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [2:0]       req0_fxn,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_fxn,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [2:0]       alu_fxn,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_c,
    output logic             rsp_v,
    input  logic             rsp_ready,
    output logic [7:0]       op_cnt0,
    output logic [7:0]       op_cnt1,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q;
    logic [2:0]       alu_fxn_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic             rsp_id_q, rsp_c_q, rsp_v_q;
    logic [WIDTH-1:0] rsp_out_q;
    logic             gnt0, gnt1, accept, capture, rsp_hs;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends on ready, and a requester may drop valid before it is accepted.
    always_comb begin
        state_d    = state_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_hs     = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the port that was not served last wins.
                gnt0       = req0_valid && (!req1_valid || last_q);
                gnt1       = req1_valid && (!req0_valid || !last_q);
                req0_ready = gnt0 && !rst;
                req1_ready = gnt1 && !rst;
                accept     = gnt0 || gnt1;
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_hs    = rsp_ready;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            alu_fxn_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            rsp_id_q  <= 1'b0;
            rsp_out_q <= '0;
            rsp_c_q   <= 1'b0;
            rsp_v_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_fxn_q <= gnt1 ? req1_fxn : req0_fxn;
                alu_a_q   <= gnt1 ? req1_a   : req0_a;
                alu_b_q   <= gnt1 ? req1_b   : req0_b;
                last_q    <= gnt1;
                rsp_id_q  <= gnt1;
            end
            // Flags pass through unmasked; the ALU already zeroes them for non-arithmetic ops.
            if (capture) begin
                rsp_out_q <= alu_out;
                rsp_c_q   <= alu_c;
                rsp_v_q   <= alu_v;
            end
        end
    end

`ifdef ALU_ARB_OPCNT_EN
    logic [7:0] op_cnt0_q, op_cnt1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt0_q <= 8'd0;
            op_cnt1_q <= 8'd0;
        end else if (rsp_hs) begin
            if (!rsp_id_q && op_cnt0_q != 8'hFF) op_cnt0_q <= op_cnt0_q + 8'd1;
            if (rsp_id_q && op_cnt1_q != 8'hFF)  op_cnt1_q <= op_cnt1_q + 8'd1;
        end
    end

    assign op_cnt0 = op_cnt0_q;
    assign op_cnt1 = op_cnt1_q;
`else
    assign op_cnt0 = 8'd0;
    assign op_cnt1 = 8'd0;
`endif

    assign alu_fxn   = alu_fxn_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_v     = rsp_v_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 6-bit ALU attached to alu_*.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

  localparam int W = 6;
  localparam int SBW = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]   req0_fxn, req1_fxn, alu_fxn;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_out;
  logic         alu_c, alu_v, rsp_valid, rsp_id, rsp_c, rsp_v, rsp_ready;
  logic [7:0]   op_cnt0, op_cnt1;
  logic [1:0]   dbg_state;
  logic [6:0]   sum7;

  int errors = 0;
  int checks = 0;
  logic [SBW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_fxn(req0_fxn), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_fxn(req1_fxn), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .alu_fxn(alu_fxn), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_c(rsp_c), .rsp_v(rsp_v),
    .rsp_ready(rsp_ready),
    .op_cnt0(op_cnt0), .op_cnt1(op_cnt1), .dbg_state(dbg_state)
  );

  // Behavioural ALU: only add/subtract produce C/V.
  always_comb begin
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum7    = '0;
    case (alu_fxn)
      3'd0: alu_out = alu_a;
      3'd1: alu_out = alu_b;
      3'd2: alu_out = -alu_a;
      3'd3: alu_out = -alu_b;
      3'd4: alu_out = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      3'd5: alu_out = ~(alu_a ^ alu_b);
      3'd6: begin
        sum7    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = sum7[W-1:0];
        alu_c   = sum7[W];
        alu_v   = (alu_a[W-1] == alu_b[W-1]) && (sum7[W-1] != alu_a[W-1]);
      end
      default: begin
        sum7    = {1'b0, alu_a} + {1'b0, ~alu_b} + 7'd1;
        alu_out = sum7[W-1:0];
        alu_c   = sum7[W];
        alu_v   = (alu_a[W-1] != alu_b[W-1]) && (sum7[W-1] != alu_a[W-1]);
      end
    endcase
  end

  // ---------------- scoreboard / checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req0(input logic v, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = v; req0_fxn = f; req0_a = a; req0_b = b;
  endtask

  task automatic drive_req1(input logic v, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = v; req1_fxn = f; req1_a = a; req1_b = b;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int grants, resps, last_cyc, acc, rsp_n;
    logic exp_gnt;
    logic [SBW-1:0] exp_v;
    logic [7:0] exp_cnt0_final, exp_cnt0_one;
`ifdef ALU_ARB_OPCNT_EN
    exp_cnt0_final = 8'd255;
    exp_cnt0_one   = 8'd1;
`else
    exp_cnt0_final = 8'd0;
    exp_cnt0_one   = 8'd0;
`endif

    rst = 1'b1;
    rsp_ready = 1'b0;
    drive_req0(1'b1, 3'd0, '0, '0);
    drive_req1(1'b0, 3'd0, '0, '0);
    repeat (2) @(negedge clk);

    // Reset values, with a request pending to show readies are held low.
    check_eq("rst_rdy0", 32'(req0_ready), 32'd0);
    check_eq("rst_rdy1", 32'(req1_ready), 32'd0);
    check_eq("rst_alu", 32'({alu_fxn, alu_a, alu_b}), 32'd0);
    check_eq("rst_rsp", 32'({rsp_valid, rsp_id, rsp_c, rsp_v, rsp_out}), 32'd0);
    check_eq("rst_cnt", 32'({op_cnt0, op_cnt1}), 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Single request: 20 + 15 = 35 overflows 6-bit signed range.
    rsp_ready = 1'b1;
    drive_req0(1'b1, 3'd6, 6'd20, 6'd15);
    #1;
    check_eq("single_rdy0", 32'(req0_ready), 32'd1);
    check_eq("single_rdy1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check_eq("single_rdy0_exec", 32'(req0_ready), 32'd0);
    check_eq("single_alu", 32'({alu_fxn, alu_a, alu_b}), 32'({3'd6, 6'd20, 6'd15}));
    check_eq("single_no_rsp", 32'(rsp_valid), 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("single_rsp", 32'({rsp_valid, rsp_id, rsp_c, rsp_v, rsp_out}),
             32'({1'b1, 1'b0, 1'b0, 1'b1, 6'd35}));
    @(negedge clk);
    check_eq("single_done", 32'(rsp_valid), 32'd0);
    check_eq("single_cnt0", 32'(op_cnt0), 32'(exp_cnt0_one));

    // Subtract with borrow: 3 - 5 = -2 -> 111110, no carry out, no overflow.
    drive_req1(1'b1, 3'd7, 6'd3, 6'd5);
    #1;
    check_eq("sub_rdy1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("sub_rsp", 32'({rsp_valid, rsp_id, rsp_c, rsp_v, rsp_out}),
             32'({1'b1, 1'b1, 1'b0, 1'b0, 6'b111110}));
    @(negedge clk);
    check_eq("sub_done", 32'(rsp_valid), 32'd0);

    // Contention: port 1 was served last, so grants go 0,1,0,1 three cycles apart.
    drive_req0(1'b1, 3'd0, 6'd5, 6'd0);
    drive_req1(1'b1, 3'd1, 6'd0, 6'd9);
    grants = 0; resps = 0; last_cyc = 0; exp_gnt = 1'b0;
    for (int cyc = 0; cyc < 60 && resps < 4; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        check_eq("cont_gnt", 32'(req1_ready), 32'(exp_gnt));
        if (grants > 0) check_eq("cont_gap", 32'(cyc - last_cyc), 32'd3);
        exp_q.push_back(exp_gnt ? {1'b1, 6'd9} : {1'b0, 6'd5});
        exp_gnt = ~exp_gnt;
        last_cyc = cyc;
        grants++;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("cont_unexpected_rsp", 32'({rsp_id, rsp_out}), 32'hFFFF);
        end else begin
          exp_v = exp_q.pop_front();
          check_eq("cont_rsp", 32'({rsp_id, rsp_out}), 32'(exp_v));
        end
        resps++;
      end
      @(negedge clk);
      if (grants == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    check_eq("cont_resps", 32'(resps), 32'd4);

    // Backpressure: XNOR(101010,110011) = 100110 held while rsp_ready is low.
    rsp_ready = 1'b0;
    drive_req0(1'b1, 3'd5, 6'b101010, 6'b110011);
    #1;
    check_eq("bp_rdy0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    drive_req1(1'b1, 3'd2, 6'd7, 6'd0);
    #1;
    check_eq("bp_exec_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("bp_hold", 32'({rsp_valid, rsp_id, rsp_c, rsp_v, rsp_out, req0_ready, req1_ready}),
               32'({1'b1, 1'b0, 1'b0, 1'b0, 6'd38, 1'b0, 1'b0}));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_release", 32'({rsp_valid, req0_ready, req1_ready}), 32'({1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    #1;
    check_eq("bp_next_gnt", 32'({req0_ready, req1_ready}), 32'({1'b0, 1'b1}));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_rsp2", 32'({rsp_valid, rsp_id, rsp_out}), 32'({1'b1, 1'b1, 6'd57}));
    @(negedge clk);

    // Reset during EXEC after a port-0 operation: nothing comes back, port 0 wins next tie.
    drive_req0(1'b1, 3'd6, 6'd1, 6'd2);
    #1;
    check_eq("rmid_rdy0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    check_eq("rmid_in_exec", 32'(dbg_state), 32'd1);
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rmid_alu", 32'({alu_fxn, alu_a, alu_b}), 32'd0);
    check_eq("rmid_state", 32'({dbg_state, rsp_valid}), 32'd0);
    @(negedge clk);
    check_eq("rmid_no_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    drive_req0(1'b1, 3'd0, 6'd5, 6'd0);
    drive_req1(1'b1, 3'd1, 6'd0, 6'd9);
    #1;
    check_eq("rmid_tie", 32'({req0_ready, req1_ready}), 32'({1'b1, 1'b0}));
    req1_valid = 1'b0;

    // Counters: 300 port-0 operations back to back.
    acc = 1; rsp_n = 0;
    for (int cyc = 0; cyc < 3000 && rsp_n < 300; cyc++) begin
      @(negedge clk);
      if (acc == 300) req0_valid = 1'b0;
      #1;
      if (req0_ready) acc++;
      if (rsp_valid) rsp_n++;
    end
    check_eq("cnt_resps", 32'(rsp_n), 32'd300);
    @(negedge clk);
    check_eq("cnt_op0", 32'(op_cnt0), 32'(exp_cnt0_final));
    check_eq("cnt_op1", 32'(op_cnt1), 32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
